fsm_stream_sequencer: RTL and testbench

Controller that drives the three sequence-detector implementations (Moore, Mealy, gate-level) from a word-level handshake. Accepts WIDTH-bit words, serializes them LSB-first onto the shared detector input, and samples all three detector outputs every bit. Per word it reports the Moore hit count and a cross-implementation mismatch flag, and it keeps a running error total. It also owns the detectors' reset sequencing, so a self-checking bench or on-chip BIST needs only this block plus the detectors.

---
 rtl/fsm_stream_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_fsm_stream_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stream_sequencer.sv
// Serializes WIDTH-bit words LSB-first into three sequence detectors and posts per-word hit/mismatch results.
// Latency: a word accepted at edge E0 has its result valid after edge E_WIDTH; words stream back-to-back.
// Backpressure: a finished result waits in the accumulators while the result slot is busy; no new word is taken until it moves to the slot.
module fsm_stream_sequencer #(
  parameter int WIDTH      = 14,
  parameter int RST_CYCLES = 10,
  parameter int CNT_W      = 16,
  parameter int HIT_W      = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              word_valid,
  input  logic [WIDTH-1:0]  word_data,
  output logic              word_ready,
  output logic              det_rstn,
  output logic              det_in,
  input  logic              det_moor,
  input  logic              det_mealy,
  input  logic              det_gate,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [HIT_W-1:0]  result_hits,
  output logic              result_err,
  output logic [CNT_W-1:0]  total_err_cnt
);

  localparam int BW  = $clog2(WIDTH);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {DRST, IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [HIT_W-1:0]   acc_hits_q, acc_hits_d;
  logic               acc_err_q, acc_err_d;
  logic               hold_q, hold_d;
  logic               res_vld_q, res_vld_d;
  logic [HIT_W-1:0]   res_hits_q, res_hits_d;
  logic               res_err_q, res_err_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               det_rstn_q, det_rstn_d;

  logic               last_bit;
  logic               slot_free;
  logic               accept;
  logic               mismatch;

  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == BW'(WIDTH - 1));
  assign slot_free = !res_vld_q || result_ready;
  assign mismatch  = !((det_moor == det_mealy) && (det_mealy == det_gate));
  assign accept    = word_valid && word_ready;

  // Word handshake: open in IDLE unless a finished result is still parked, and on the last bit only if the slot frees up
  always_comb begin
    word_ready = 1'b0;
    if (state_q == IDLE) begin
      word_ready = !hold_q;
    end else if (last_bit) begin
      word_ready = slot_free;
    end
  end

  // Next-state, sampling and result-slot logic; clear overrides everything at the end
  always_comb begin
    logic [HIT_W-1:0] hits_next;
    logic             err_next;

    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    acc_hits_d = acc_hits_q;
    acc_err_d  = acc_err_q;
    hold_d     = hold_q;
    res_vld_d  = res_vld_q;
    res_hits_d = res_hits_q;
    res_err_d  = res_err_q;
    total_d    = total_q;
    hits_next  = acc_hits_q + HIT_W'(det_moor);
    err_next   = acc_err_q | mismatch;

    if (res_vld_q && result_ready) begin
      res_vld_d = 1'b0;
    end

    case (state_q)
      DRST: begin
        if (rst_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q - RCW'(1);
        end
      end

      IDLE: begin
        // A result parked behind a busy slot moves over as soon as the slot frees
        if (hold_q && slot_free) begin
          res_vld_d  = 1'b1;
          res_hits_d = acc_hits_q;
          res_err_d  = acc_err_q;
          acc_hits_d = '0;
          acc_err_d  = 1'b0;
          hold_d     = 1'b0;
        end
        if (accept) begin
          shreg_d   = word_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (mismatch && (total_q != {CNT_W{1'b1}})) begin
          total_d = total_q + CNT_W'(1);
        end
        if (last_bit) begin
          if (slot_free) begin
            res_vld_d  = 1'b1;
            res_hits_d = hits_next;
            res_err_d  = err_next;
            acc_hits_d = '0;
            acc_err_d  = 1'b0;
          end else begin
            acc_hits_d = hits_next;
            acc_err_d  = err_next;
            hold_d     = 1'b1;
          end
          if (accept) begin
            shreg_d   = word_data;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          acc_hits_d = hits_next;
          acc_err_d  = err_next;
        end
      end

      default: state_d = DRST;
    endcase

    if (clear) begin
      state_d    = DRST;
      rst_cnt_d  = RCW'(RST_CYCLES);
      bit_cnt_d  = '0;
      shreg_d    = '0;
      acc_hits_d = '0;
      acc_err_d  = 1'b0;
      hold_d     = 1'b0;
      res_vld_d  = 1'b0;
      res_hits_d = '0;
      res_err_d  = 1'b0;
      total_d    = '0;
    end

    det_rstn_d = (state_d != DRST);
  end

  // State register; rstn has priority over clear and over every handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= DRST;
      rst_cnt_q  <= RCW'(RST_CYCLES);
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      acc_hits_q <= '0;
      acc_err_q  <= 1'b0;
      hold_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_hits_q <= '0;
      res_err_q  <= 1'b0;
      total_q    <= '0;
      det_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      acc_hits_q <= acc_hits_d;
      acc_err_q  <= acc_err_d;
      hold_q     <= hold_d;
      res_vld_q  <= res_vld_d;
      res_hits_q <= res_hits_d;
      res_err_q  <= res_err_d;
      total_q    <= total_d;
      det_rstn_q <= det_rstn_d;
    end
  end

  assign det_rstn      = det_rstn_q;
  assign det_in        = (state_q == SHIFT) && shreg_q[0];
  assign result_valid  = res_vld_q;
  assign result_hits   = res_hits_q;
  assign result_err    = res_err_q;
  assign total_err_cnt = total_q;

endmodule

// File: tb/tb_fsm_stream_sequencer.sv
// Bench for fsm_stream_sequencer: stub detectors, transaction-level reference model, per-cycle compare.
// Directed scenarios (reset, single word, streaming, mismatch, backpressure, clear) then random traffic.
// Inputs change 1 time unit after the rising edge; outputs are compared 3 units after it.
module tb_fsm_stream_sequencer;
  localparam int W  = 14;
  localparam int RC = 10;
  localparam int CW = 16;
  localparam int HW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rstn, clear, word_valid, result_ready;
  logic [W-1:0]  word_data;
  logic          word_ready, det_rstn, det_in, result_valid, result_err;
  logic          det_moor, det_mealy, det_gate;
  logic [HW-1:0] result_hits;
  logic [CW-1:0] total_err_cnt;

  always #5 clk = ~clk;

  // Stub detectors: plain mode follows det_in; pattern mode flags "1101" (oldest first) including the current bit
  logic       mode, inject;
  logic [2:0] hist;
  logic       base;
  always @(posedge clk) begin
    if (!det_rstn) hist <= 3'b000;
    else           hist <= {hist[1:0], det_in};
  end
  assign base      = mode ? ({hist, det_in} == 4'b1101) : det_in;
  assign det_moor  = base;
  assign det_mealy = base;
  assign det_gate  = base ^ inject;

  fsm_stream_sequencer #(.WIDTH(W), .RST_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .clear(clear),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .det_rstn(det_rstn), .det_in(det_in),
    .det_moor(det_moor), .det_mealy(det_mealy), .det_gate(det_gate),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hits(result_hits), .result_err(result_err),
    .total_err_cnt(total_err_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model in transaction terms: reset countdown, bits left in the word, a pending slot and a parked result
  int         m_rst_left, m_bits, m_ahits, m_phits, m_total, m_wcnt;
  logic [W-1:0] m_sh;
  logic       m_pend, m_perr, m_aerr, m_hold, m_acc;
  logic [2:0] m_mh;
  logic       chk_en;

  int   log_hits[$];
  logic log_err[$];
  logic [W-1:0] wq[$];

  function automatic logic m_ready();
    return (m_rst_left == 0) &&
           ((m_bits == 0 && !m_hold) || (m_bits == 1 && (!m_pend || result_ready)));
  endfunction

  task automatic model_reset();
    m_rst_left = RC + 1;
    m_bits = 0; m_sh = '0;
    m_pend = 1'b0; m_phits = 0; m_perr = 1'b0;
    m_hold = 1'b0; m_ahits = 0; m_aerr = 1'b0;
    m_total = 0; m_mh = 3'b000;
  endtask

  task automatic model_post();
    m_pend = 1'b1; m_phits = m_ahits; m_perr = m_aerr;
    m_ahits = 0; m_aerr = 1'b0;
  endtask

  task automatic model_edge();
    logic rdy, take, free, d_in, d;
    logic [2:0] new_mh;
    m_acc = 1'b0;
    if (!rstn || clear) begin
      model_reset();
      return;
    end
    rdy  = m_ready();
    take = m_pend && result_ready;
    free = !m_pend || result_ready;
    d_in = (m_bits > 0) ? m_sh[0] : 1'b0;
    if (m_bits > 0) begin
      d = mode ? ({m_mh, d_in} == 4'b1101) : d_in;
      m_ahits += int'(d);
      if (inject) begin
        m_aerr = 1'b1;
        if (m_total < 65535) m_total++;
      end
    end
    if (take) m_pend = 1'b0;
    if (m_bits == 1) begin
      if (free) model_post();
      else      m_hold = 1'b1;
    end else if (m_hold && free) begin
      model_post();
      m_hold = 1'b0;
    end
    new_mh = (m_rst_left == 0) ? {m_mh[1:0], d_in} : 3'b000;
    if (m_bits > 0) begin
      m_bits--;
      m_sh = m_sh >> 1;
    end
    if (word_valid && rdy) begin
      m_acc = 1'b1; m_sh = word_data; m_bits = W; m_wcnt++;
    end
    if (m_rst_left > 0) m_rst_left--;
    m_mh = new_mh;
  endtask

  task automatic compare();
    if (!chk_en) return;
    chk("det_rstn", det_rstn, m_rst_left == 0);
    chk("word_ready", word_ready, m_ready());
    chk("det_in", det_in, (m_bits > 0) ? m_sh[0] : 1'b0);
    chk("result_valid", result_valid, m_pend);
    if (m_pend) begin
      chk("result_hits", result_hits, m_phits);
      chk("result_err", result_err, m_perr);
    end
    chk("total_err_cnt", total_err_cnt, m_total);
    if (result_valid && result_ready) begin
      log_hits.push_back(int'(result_hits));
      log_err.push_back(result_err);
    end
  endtask

  task automatic step();
    #2;
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fstep();
    word_valid = (wq.size() > 0);
    if (wq.size() > 0) word_data = wq[0];
    step();
    if (m_acc) void'(wq.pop_front());
  endtask

  initial begin
    int low, n, ones;
    logic [W-1:0] seen;
    rstn = 1'b0; clear = 1'b0; word_valid = 1'b0; word_data = '0;
    result_ready = 1'b1; mode = 1'b0; inject = 1'b0; chk_en = 1'b0; m_wcnt = 0;
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;

    // Reset held three cycles, then count det_rstn-low cycles after the first released edge
    repeat (3) begin
      step();
      chk("rst_hits", result_hits, 0);
      chk("rst_err", result_err, 0);
    end
    rstn = 1'b1;
    low = 0;
    repeat (20) begin
      step();
      if (!det_rstn) low++;
    end
    chk("rst_low_cycles", low, RC);

    // Single word 0x0007 through det_in-following detectors
    mode = 1'b0;
    wq.push_back(14'h0007);
    n = 0;
    while (!m_acc && n < 5) begin fstep(); n++; end
    chk("single_accepted", m_acc, 1'b1);
    word_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      seen[k] = det_in;
      step();
    end
    chk("single_bits", seen, 14'h0007);
    chk("single_valid", result_valid, 1'b1);
    chk("single_hits", result_hits, 3);
    chk("single_err", result_err, 1'b0);
    step();

    // Gapless streaming of 0,7,...,497 through the pattern detectors
    mode = 1'b1;
    log_hits.delete(); log_err.delete();
    for (int w = 0; w <= 497; w += 7) wq.push_back(W'(w));
    n = 0;
    while (log_err.size() < 72 && n < 1200) begin fstep(); n++; end
    chk("stream_results", log_err.size(), 72);
    chk("stream_cycles", n, 72 * W + 2);
    ones = 0;
    foreach (log_err[i]) if (log_err[i]) ones++;
    chk("stream_err_words", ones, 0);
    chk("stream_total", total_err_cnt, 0);

    // Mismatch on the 5th bit of the 2nd of three words
    log_hits.delete(); log_err.delete();
    m_wcnt = 0;
    repeat (3) wq.push_back(W'($urandom));
    repeat (60) begin
      inject = (m_wcnt == 2) && (m_bits == W - 4);
      fstep();
    end
    inject = 1'b0;
    chk("inj_results", log_err.size(), 3);
    if (log_err.size() == 3) begin
      chk("inj_err_w1", log_err[0], 1'b0);
      chk("inj_err_w2", log_err[1], 1'b1);
      chk("inj_err_w3", log_err[2], 1'b0);
    end
    chk("inj_total", total_err_cnt, 1);

    // Backpressure: two words with the consumer stalled, then released
    mode = 1'b0;
    result_ready = 1'b0;
    log_hits.delete(); log_err.delete();
    wq.push_back(14'h000F);
    wq.push_back(14'h0003);
    repeat (50) fstep();
    chk("bp_queue_drained", wq.size(), 0);
    chk("bp_pending_valid", result_valid, 1'b1);
    chk("bp_pending_hits", result_hits, 4);
    result_ready = 1'b1;
    repeat (5) fstep();
    chk("bp_results", log_hits.size(), 2);
    if (log_hits.size() == 2) begin
      chk("bp_hits_w1", log_hits[0], 4);
      chk("bp_hits_w2", log_hits[1], 2);
    end

    // Clear at bit 6 of a word while a result is pending
    result_ready = 1'b0;
    m_wcnt = 0;
    wq.push_back(14'h1234);
    wq.push_back(14'h2AAA);
    n = 0;
    while (!(m_wcnt == 2 && m_bits == W - 6) && n < 60) begin
      inject = (m_wcnt == 2) && (m_bits == W - 2);
      fstep();
      n++;
    end
    inject = 1'b0;
    chk("clr_reached_bit6", n < 60, 1'b1);
    chk("clr_pending_before", result_valid, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", result_valid, 1'b0);
    chk("clr_total", total_err_cnt, 0);
    chk("clr_det_rstn", det_rstn, 1'b0);
    wq.delete();
    word_valid = 1'b0;
    result_ready = 1'b1;
    log_hits.delete(); log_err.delete();
    low = 0;
    repeat (30) begin
      step();
      if (!det_rstn) low++;
    end
    chk("clr_low_cycles", low, RC);
    chk("clr_no_result", log_err.size(), 0);

    // Random traffic with occasional mismatches and clears
    mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      word_valid   = ($urandom_range(0, 3) != 0);
      word_data    = W'($urandom);
      result_ready = ($urandom_range(0, 3) != 0);
      inject       = ($urandom_range(0, 15) == 0);
      clear        = ($urandom_range(0, 299) == 0);
      step();
    end
    clear = 1'b0; inject = 1'b0; word_valid = 1'b0; result_ready = 1'b1;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
